// File: rtl/baud_pkg.sv
// Purpose: shared constants, state encoding and helpers for the UART baud timebase.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by the timebase: BAUD_RESYNC_EN.
package baud_pkg;

  localparam int DIV_W_DEF     = 16;   // divisor / divide counter width
  localparam int OS_RATE_DEF   = 16;   // os_ticks per bit_tick
  localparam int RESET_DIV_DEF = 651;  // 100 MHz / 9600 / 16

  // Phase counter width for the default oversample rate.
  localparam int PHASE_W = $clog2(OS_RATE_DEF);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Phase counter width for an arbitrary oversample rate (at least 1 bit).
  function automatic int phase_w(input int os_rate);
    return (os_rate < 2) ? 1 : $clog2(os_rate);
  endfunction

endpackage

// File: rtl/baud_div_counter.sv
// Purpose: clk divider (div_cnt) and oversample phase counter (phase_cnt) producing os/bit ticks.
// Latency: ticks are combinational from the counter registers; counters update every edge.
// Backpressure: none; the timebase free-runs while run=1.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   run           controller is in a counting state
//   clear         zero both counters next edge (highest priority)
//   load_mid      restart mid-bit: div_cnt<=0, phase_cnt<=OS_RATE/2; suppresses ticks this cycle
//   div           divisor in effect (never 0)
//   bit_wrap      raw end-of-bit indication, not suppressed by load_mid
//   os_tick       oversample tick
//   bit_tick      bit tick
module baud_div_counter
  import baud_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int OS_RATE = OS_RATE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             load_mid,
  input  logic [DIV_W-1:0] div,
  output logic             bit_wrap,
  output logic             os_tick,
  output logic             bit_tick
);

  localparam int PW = phase_w(OS_RATE);
  localparam logic [PW-1:0] PH_LAST = PW'(OS_RATE - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OS_RATE / 2);

  logic [DIV_W-1:0] div_cnt;
  logic [PW-1:0]    phase_cnt;
  logic [DIV_W-1:0] div_last;
  logic             os_wrap;

  assign div_last = div - DIV_W'(1);
  assign os_wrap  = run && (div_cnt == div_last);
  assign bit_wrap = os_wrap && (phase_cnt == PH_LAST);
  assign os_tick  = os_wrap && !load_mid;
  assign bit_tick = bit_wrap && !load_mid;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt   <= '0;
      phase_cnt <= '0;
    end else if (load_mid) begin
      div_cnt   <= '0;
      phase_cnt <= PH_MID;
    end else if (run) begin
      if (os_wrap) begin
        div_cnt   <= '0;
        // OS_RATE is a power of two, so the natural wrap of PW bits is the wrap at OS_RATE-1.
        phase_cnt <= phase_cnt + PW'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Purpose: UART baud timebase controller: FSM, shadow divisor and host config handshake.
// Latency: cfg accepted on the ready&valid edge; new divisor takes effect at the next bit boundary.
// Backpressure: cfg_ready drops while a divisor is pending and while rst is high.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            level; 1 = timebase running
//   resync        (only with BAUD_RESYNC_EN) restart the bit phase mid-bit
//   cfg_valid / cfg_ready / cfg_divisor   host divisor handshake
//   cfg_err       1-cycle pulse after a zero divisor was accepted (and ignored)
//   os_tick       oversample tick, bit_tick every OS_RATE-th os_tick
//   cur_div       divisor in effect, pending = a divisor waits for a bit boundary
// Build option: define BAUD_RESYNC_EN to add the resync input.
module baud_ctrl
  import baud_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int OS_RATE   = OS_RATE_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef BAUD_RESYNC_EN
  input  logic             resync,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_divisor,
  output logic             cfg_err,
  output logic             os_tick,
  output logic             bit_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             pending
);

  state_t           state;
  logic [DIV_W-1:0] shadow;

  logic running;
  logic accept;
  logic accept_nz;
  logic bit_wrap;
  logic apply;
  logic clear;
  logic resync_eff;
  logic cnt_os;
  logic cnt_bit;

  assign running   = (state != OFF);
  assign cfg_ready = !rst && (state != PEND);
  assign accept    = cfg_valid && cfg_ready;
  assign accept_nz = accept && (cfg_divisor != '0);

  // The shadow divisor lands either at the end of the current bit or
  // immediately when the timebase is switched off while one is waiting.
  assign apply = (state == PEND) && (bit_wrap || !en);

  // Counters restart from zero in OFF, when leaving RUN, and whenever a new
  // divisor is applied, so the first bit under any divisor is full length.
  assign clear = (state == OFF) || ((state == RUN) && !en) || apply;

`ifdef BAUD_RESYNC_EN
  // Applying a pending divisor owns the counters in that cycle.
  assign resync_eff = resync && running && !apply;
`else
  assign resync_eff = 1'b0;
`endif

  baud_div_counter #(
    .DIV_W   (DIV_W),
    .OS_RATE (OS_RATE)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (running),
    .clear    (clear),
    .load_mid (resync_eff),
    .div      (cur_div),
    .bit_wrap (bit_wrap),
    .os_tick  (cnt_os),
    .bit_tick (cnt_bit)
  );

  assign os_tick  = !rst && cnt_os;
  assign bit_tick = !rst && cnt_bit;
  assign pending  = (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OFF;
      cur_div <= DIV_W'(RESET_DIV);
      shadow  <= '0;
      cfg_err <= 1'b0;
    end else begin
      // A zero divisor completes the handshake but changes nothing else.
      cfg_err <= accept && (cfg_divisor == '0);
      case (state)
        OFF: begin
          if (accept_nz) cur_div <= cfg_divisor;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            // Timebase is stopping, so there is no bit to protect: take it directly.
            state <= OFF;
            if (accept_nz) cur_div <= cfg_divisor;
          end else if (accept_nz) begin
            shadow <= cfg_divisor;
            state  <= PEND;
          end
        end
        PEND: begin
          if (apply) begin
            cur_div <= shadow;
            state   <= en ? RUN : OFF;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_ctrl.sv
// Purpose: self-checking bench for baud_ctrl against an elapsed-time reference model.
// Latency: model predicts each cycle's outputs from elapsed RUN time and the divisor.
// Backpressure: model tracks cfg_ready from its own pending flag.
module tb_baud_ctrl;

  localparam int DIV_W     = 16;
  localparam int OS_RATE   = 16;
  localparam int RESET_DIV = 651;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_divisor = '0;
  logic             resync = 1'b0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             os_tick;
  logic             bit_tick;
  logic [DIV_W-1:0] cur_div;
  logic             pending;

  baud_ctrl #(
    .DIV_W     (DIV_W),
    .OS_RATE   (OS_RATE),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
`ifdef BAUD_RESYNC_EN
    .resync      (resync),
`endif
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_divisor (cfg_divisor),
    .cfg_err     (cfg_err),
    .os_tick     (os_tick),
    .bit_tick    (bit_tick),
    .cur_div     (cur_div),
    .pending     (pending)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int os_q[$];
  int bit_q[$];

  // Reference model: m_t = cycles elapsed in the current bit-timing epoch.
  int m_on     = 0;
  int m_pend   = 0;
  int m_err    = 0;
  int m_div    = RESET_DIV;
  int m_shadow = 0;
  int m_t      = 0;

  int e, b, idx;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1000000;
  endfunction

  // One clock cycle: inputs are already driven (after a negedge).
  task automatic step();
    int raw_os, raw_bit, apply, rs, ready, acc, nz, period;
    #1;
    ready   = (!rst && m_pend == 0) ? 1 : 0;
    raw_os  = (m_on != 0 && (m_t % m_div) == m_div - 1) ? 1 : 0;
    raw_bit = (m_on != 0 && m_t == m_div * OS_RATE - 1) ? 1 : 0;
    apply   = (m_pend != 0 && (raw_bit != 0 || !en)) ? 1 : 0;
    rs      = (resync && m_on != 0 && apply == 0) ? 1 : 0;
    chk("cfg_ready", int'(cfg_ready), ready);
    chk("os_tick",   int'(os_tick),  (!rst && raw_os != 0 && rs == 0) ? 1 : 0);
    chk("bit_tick",  int'(bit_tick), (!rst && raw_bit != 0 && rs == 0) ? 1 : 0);
    chk("cfg_err",   int'(cfg_err), m_err);
    chk("cur_div",   int'(cur_div), m_div);
    chk("pending",   int'(pending), m_pend);
    if (os_tick)  os_q.push_back(cyc);
    if (bit_tick) bit_q.push_back(cyc);
    acc = (cfg_valid && ready != 0) ? 1 : 0;
    nz  = (cfg_divisor != 0) ? 1 : 0;
    @(posedge clk);
    period = m_div * OS_RATE;
    if (rst) begin
      m_on = 0; m_pend = 0; m_err = 0; m_div = RESET_DIV; m_shadow = 0; m_t = 0;
    end else begin
      m_err = (acc != 0 && nz == 0) ? 1 : 0;
      if (m_on == 0) begin
        if (acc != 0 && nz != 0) m_div = int'(cfg_divisor);
        if (en) begin m_on = 1; m_t = 0; end
      end else if (m_pend == 0) begin
        if (!en) begin
          m_on = 0; m_t = 0;
          if (acc != 0 && nz != 0) m_div = int'(cfg_divisor);
        end else begin
          m_t = (rs != 0) ? (OS_RATE / 2) * m_div : (m_t + 1) % period;
          if (acc != 0 && nz != 0) begin m_shadow = int'(cfg_divisor); m_pend = 1; end
        end
      end else begin
        if (apply != 0) begin
          m_div = m_shadow; m_pend = 0; m_t = 0; m_on = en ? 1 : 0;
        end else begin
          m_t = (rs != 0) ? (OS_RATE / 2) * m_div : (m_t + 1) % period;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic cfg(input int d);
    cfg_valid   = 1'b1;
    cfg_divisor = DIV_W'(d);
    step();
    cfg_valid   = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    run(2);
    chk("rst_ready_low", int'(cfg_ready), 0);
    chk("rst_cur_div", int'(cur_div), 651);
    rst = 1'b0;
    run(1);
    chk("off_ready", int'(cfg_ready), 1);
    chk("off_pending", int'(pending), 0);
    cfg(4);
    chk("off_cfg_div", int'(cur_div), 4);

    // Divisor 4: first os_tick in RUN cycle 4, bit_tick every 64 cycles.
    os_q.delete(); bit_q.delete();
    en = 1'b1; e = cyc;
    run(131);
    chk("first_os_lat4", qget(os_q, 0) - e, 4);
    chk("os_period4", qget(os_q, 1) - qget(os_q, 0), 4);
    chk("first_bit_lat", qget(bit_q, 0) - e, 64);
    chk("bit_period64", qget(bit_q, 1) - qget(bit_q, 0), 64);

    // Mid-bit change to 2: old period holds until the bit boundary.
    os_q.delete(); bit_q.delete();
    cfg(2);
    chk("pend_set", int'(pending), 1);
    chk("pend_ready_low", int'(cfg_ready), 0);
    run(100);
    b = qget(bit_q, 0);
    idx = -1;
    for (int k = 0; k < os_q.size(); k++) if (os_q[k] == b) idx = k;
    chk("old_period_kept", qget(os_q, idx) - qget(os_q, idx - 1), 4);
    chk("new_period", qget(os_q, idx + 1) - qget(os_q, idx), 2);
    chk("new_bit_len", qget(bit_q, 1) - b, 32);

    // Zero divisor: error pulse, nothing else changes.
    cfg(0);
    chk("err_pulse", int'(cfg_err), 1);
    chk("err_cur_div", int'(cur_div), 2);
    chk("err_no_pend", int'(pending), 0);
    run(1);
    chk("err_one_cycle", int'(cfg_err), 0);

    // en=0 while 7 is pending: applied immediately, then 7-cycle latency.
    cfg(7);
    chk("pend7", int'(pending), 1);
    en = 1'b0;
    run(1);
    chk("off_apply_div", int'(cur_div), 7);
    chk("off_apply_pend", int'(pending), 0);
    os_q.delete();
    run(10);
    chk("off_no_ticks", os_q.size(), 0);
    en = 1'b1; e = cyc;
    run(30);
    chk("first_os_lat7", qget(os_q, 0) - e, 7);
    chk("os_period7", qget(os_q, 1) - qget(os_q, 0), 7);

    // Divisor 1: os_tick every RUN cycle, bit_tick every 16.
    en = 1'b0;
    run(1);
    cfg(1);
    os_q.delete(); bit_q.delete();
    en = 1'b1; e = cyc;
    run(40);
    chk("first_os_lat1", qget(os_q, 0) - e, 1);
    chk("os_period1", qget(os_q, 1) - qget(os_q, 0), 1);
    chk("first_bit_lat1", qget(bit_q, 0) - e, 16);
    chk("bit_period16", qget(bit_q, 1) - qget(bit_q, 0), 16);

    // Reset while pending discards the shadow.
    cfg(5);
    chk("pend5", int'(pending), 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("rst_pend_div", int'(cur_div), 651);
    chk("rst_pend_flag", int'(pending), 0);
    run(20);
    chk("shadow_lost", int'(cur_div), 651);

`ifdef BAUD_RESYNC_EN
    begin
      int r;
      en = 1'b0;
      run(1);
      cfg(3);
      en = 1'b1;
      run(20);
      os_q.delete(); bit_q.delete();
      resync = 1'b1; r = cyc;
      step();
      resync = 1'b0;
      run(60);
      chk("rs_no_tick", (qget(os_q, 0) == r) ? 1 : 0, 0);
      chk("rs_bit_lat", qget(bit_q, 0) - r, 24);
    end
`endif

    // Randomized traffic against the model.
    en = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      rst         = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 149) == 0) en = ~en;
      cfg_valid   = ($urandom_range(0, 29) == 0);
      cfg_divisor = DIV_W'($urandom_range(0, 6));
`ifdef BAUD_RESYNC_EN
      resync      = ($urandom_range(0, 99) == 0);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
